// File: rtl/cache_sim_pkg.sv
// ---------------------------------------------------------------------------
// cache_sim_pkg
// Shared definitions for the multicore cache simulator memory path:
//   - log2      : ceiling log2 used to derive id / offset widths
//   - ADDR_W_DEF: default byte address width of main memory
//   - fill_state_e: fill sequencer states
// ---------------------------------------------------------------------------
package cache_sim_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fill_state_e;

  // Ceiling log2; used only at elaboration time.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_fill_arbiter_if
// Bundles the core-side miss/fill handshake and the BRAM read port.
//   master : the environment (cache controllers + BRAM) -- drives req,
//            req_addr and mem_dout, observes everything else
//   slave  : the fill arbiter itself
// Signals:
//   req[NUM_CORES], req_addr[NUM_CORES*ADDR_W] (core i at [i*ADDR_W +: ADDR_W])
//   ack[NUM_CORES], fill_valid, fill_core, fill_block (byte k at [8k +: 8]),
//   busy, mem_en, mem_addr, mem_dout
// ---------------------------------------------------------------------------
interface mem_fill_arbiter_if
  import cache_sim_pkg::*;
#(
  parameter int NUM_CORES       = 4,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int ADDR_W          = ADDR_W_DEF
) ();

  localparam int CORE_ID_W = log2(NUM_CORES);

  logic [NUM_CORES-1:0]         req;
  logic [NUM_CORES*ADDR_W-1:0]  req_addr;
  logic [NUM_CORES-1:0]         ack;
  logic                         fill_valid;
  logic [CORE_ID_W-1:0]         fill_core;
  logic [BLOCK_SIZE_BYTE*8-1:0] fill_block;
  logic                         busy;
  logic                         mem_en;
  logic [ADDR_W-1:0]            mem_addr;
  logic [7:0]                   mem_dout;

  modport master (
    output req, req_addr, mem_dout,
    input  ack, fill_valid, fill_core, fill_block, busy, mem_en, mem_addr
  );

  modport slave (
    input  req, req_addr, mem_dout,
    output ack, fill_valid, fill_core, fill_block, busy, mem_en, mem_addr
  );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set req bit searching upward from
// rr_ptr, wrapping modulo NUM_CORES. The pointer register lives in the parent.
//   req         : pending requests
//   rr_ptr      : highest-priority core this round
//   grant       : one-hot winner (all zero when nothing pending)
//   grant_id    : encoded winner
//   grant_valid : any request pending
// ---------------------------------------------------------------------------
module rr_arbiter
  import cache_sim_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int CORE_ID_W = log2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [CORE_ID_W-1:0] rr_ptr,
  output logic [NUM_CORES-1:0] grant,
  output logic [CORE_ID_W-1:0] grant_id,
  output logic                 grant_valid
);

  logic [CORE_ID_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the search loop; a path
    // that skips an assignment would otherwise infer a latch.
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      // NUM_CORES is a power of two, so the add wraps modulo NUM_CORES.
      idx = rr_ptr + CORE_ID_W'(i);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/mem_fill_arbiter.sv
// ---------------------------------------------------------------------------
// mem_fill_arbiter
// Shares the byte-wide main-memory BRAM among per-core L1 miss paths.
// A round-robin pick selects one pending miss; the block then issues
// BLOCK_SIZE_BYTE byte reads, assembles the line and returns it with a
// one-cycle fill_valid / ack pulse.
// Ports:
//   clk3  : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_fill_arbiter_if.slave (core handshake + BRAM read port)
// Timing: req seen at edge 0, reads issued in cycles 1..B, fill_valid in
// cycle B+MEM_LAT+1, then at least one IDLE cycle before the next grant.
// ---------------------------------------------------------------------------
module mem_fill_arbiter
  import cache_sim_pkg::*;
#(
  parameter int NUM_CORES       = 4,
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int MEM_LAT         = 1
) (
  input logic               clk3,
  input logic               reset,
  mem_fill_arbiter_if.slave bus
);

  localparam int CORE_ID_W = log2(NUM_CORES);
  localparam int BO_W      = log2(BLOCK_SIZE_BYTE);
  localparam logic [BO_W-1:0]   LAST_BYTE = BO_W'(BLOCK_SIZE_BYTE - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BLOCK_SIZE_BYTE - 1);

  fill_state_e                  state_q;
  logic [CORE_ID_W-1:0]         rr_ptr_q;
  logic [CORE_ID_W-1:0]         cur_core_q;
  logic [NUM_CORES-1:0]         cur_grant_q;
  logic [ADDR_W-1:0]            base_q;
  logic [BO_W-1:0]              issue_cnt_q;
  logic [BO_W-1:0]              cap_cnt_q;
  logic [MEM_LAT-1:0]           vld_pipe_q;
  logic                         mem_en_q;
  logic [ADDR_W-1:0]            mem_addr_q;
  logic                         busy_q;
  logic [NUM_CORES-1:0]         ack_q;
  logic                         fill_valid_q;
  logic [CORE_ID_W-1:0]         fill_core_q;
  logic [BLOCK_SIZE_BYTE*8-1:0] fill_block_q;

  logic [NUM_CORES-1:0] grant;
  logic [CORE_ID_W-1:0] grant_id;
  logic                 grant_valid;
  logic [ADDR_W-1:0]    line_base;
  logic                 cap_vld;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .CORE_ID_W (CORE_ID_W)
  ) u_rr_arbiter (
    .req         (bus.req),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign line_base = bus.req_addr[grant_id*ADDR_W +: ADDR_W] & LINE_MASK;
  assign cap_vld   = vld_pipe_q[MEM_LAT-1];

  // Fill sequencer with registered outputs.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cur_core_q   <= '0;
      cur_grant_q  <= '0;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      busy_q       <= 1'b0;
      ack_q        <= '0;
      fill_valid_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values, independent of statement order.
      ack_q        <= '0;
      fill_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            cur_core_q  <= grant_id;
            cur_grant_q <= grant;
            base_q      <= line_base;
            mem_addr_q  <= line_base;
            mem_en_q    <= 1'b1;
            issue_cnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_cnt_q == LAST_BYTE) begin
            mem_en_q <= 1'b0;
            state_q  <= DRAIN;
          end else begin
            issue_cnt_q <= issue_cnt_q + 1'b1;
            // Only the offset bits change, so the address stays in the line.
            mem_addr_q  <= base_q | ADDR_W'(issue_cnt_q + 1'b1);
          end
        end
        DRAIN: begin
          // Leave on the edge that captures the last byte so the pulse
          // lines up with the completed line.
          if (cap_vld && cap_cnt_q == LAST_BYTE) begin
            fill_valid_q <= 1'b1;
            ack_q        <= cur_grant_q;
            state_q      <= DONE;
          end
        end
        DONE: begin
          rr_ptr_q <= cur_core_q + 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-return tracking and line assembly. The valid pipe mirrors the BRAM
  // latency; the capture counter wraps to zero after the last byte.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      vld_pipe_q   <= '0;
      cap_cnt_q    <= '0;
      fill_core_q  <= '0;
      // NOTE: the line buffer is a flop array, not a RAM macro, so it
      // takes the reset like any other register and reads 0 afterwards.
      fill_block_q <= '0;
    end else begin
      vld_pipe_q[0] <= mem_en_q;
      for (int i = 1; i < MEM_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
      if (cap_vld) begin
        fill_block_q[8*cap_cnt_q +: 8] <= bus.mem_dout;
        cap_cnt_q                      <= cap_cnt_q + 1'b1;
        if (cap_cnt_q == '0) fill_core_q <= cur_core_q;
      end
    end
  end

  assign bus.ack        = ack_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_core  = fill_core_q;
  assign bus.fill_block = fill_block_q;
  assign bus.busy       = busy_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_fill_arbiter
// Main DUT: 4 cores, 16-byte lines, MEM_LAT=1, checked every cycle against a
// transaction-timeline model. Second DUT: 4-byte lines, MEM_LAT=2, checked
// with literal expectations. BRAM models return the low address byte.
// ---------------------------------------------------------------------------
module tb_mem_fill_arbiter;
  import cache_sim_pkg::*;

  localparam int N      = 4;
  localparam int B      = 16;
  localparam int L      = 1;
  localparam int AW     = 16;
  localparam int FILL_T = B + L + 1;  // cycle index of the fill_valid pulse

  logic clk3  = 1'b0;
  logic reset = 1'b0;
  always #5 clk3 = ~clk3;

  mem_fill_arbiter_if #(.NUM_CORES(N), .BLOCK_SIZE_BYTE(B), .ADDR_W(AW)) bus ();
  mem_fill_arbiter_if #(.NUM_CORES(N), .BLOCK_SIZE_BYTE(4), .ADDR_W(AW)) bus2 ();

  mem_fill_arbiter #(
    .NUM_CORES(N), .BLOCK_SIZE_BYTE(B), .ADDR_W(AW), .MEM_LAT(L)
  ) dut (
    .clk3  (clk3),
    .reset (reset),
    .bus   (bus.slave)
  );

  mem_fill_arbiter #(
    .NUM_CORES(N), .BLOCK_SIZE_BYTE(4), .ADDR_W(AW), .MEM_LAT(2)
  ) dut2 (
    .clk3  (clk3),
    .reset (reset),
    .bus   (bus2.slave)
  );

  // BRAM models: data = low address byte, MEM_LAT cycles after sampling.
  logic [7:0] bram2_s1;
  always @(posedge clk3) begin
    if (bus.mem_en) bus.mem_dout <= bus.mem_addr[7:0];
  end
  always @(posedge clk3) begin
    if (bus2.mem_en) bram2_s1 <= bus2.mem_addr[7:0];
    bus2.mem_dout <= bram2_s1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each fill is a fixed timeline counted from its grant.
  // m_t = cycle index within the current fill (1..FILL_T), -1 when idle.
  int          m_t   = -1;
  int          m_cur = 0;
  int          m_rr  = 0;
  logic [15:0] m_base = '0;
  int          fills_seen = 0;

  always @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      m_t  = -1;
      m_rr = 0;
    end else if (m_t < 0) begin
      if (bus.req != '0) begin
        bit found;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_rr + i) % N;
          if (!found && bus.req[c]) begin
            found = 1'b1;
            m_cur = c;
          end
        end
        m_base = bus.req_addr[m_cur*AW +: AW] & 16'hFFF0;
        m_t    = 1;
      end
    end else if (m_t == FILL_T) begin
      m_t  = -1;
      m_rr = (m_cur + 1) % N;
    end else begin
      m_t++;
    end
  end

  // Per-cycle compare of the main DUT against the model.
  always @(negedge clk3) begin
    if (!reset) begin
      check("rst_busy", bus.busy, 0);
      check("rst_mem_en", bus.mem_en, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_ack", bus.ack, 0);
      check("rst_fill_valid", bus.fill_valid, 0);
      check("rst_fill_core", bus.fill_core, 0);
      check("rst_fill_block", bus.fill_block, 0);
    end else begin
      logic exp_en;
      logic exp_fv;
      exp_en = (m_t >= 1) && (m_t <= B);
      exp_fv = (m_t == FILL_T);
      check("mem_en", bus.mem_en, exp_en);
      if (exp_en) check("mem_addr", bus.mem_addr, m_base | 16'(m_t - 1));
      check("busy", bus.busy, m_t >= 1);
      check("fill_valid", bus.fill_valid, exp_fv);
      check("ack", bus.ack, exp_fv ? (4'b0001 << m_cur) : 4'b0000);
      if (exp_fv) begin
        logic [127:0] line;
        for (int k = 0; k < B; k++) line[8*k +: 8] = m_base[7:0] + 8'(k);
        check("fill_core", bus.fill_core, m_cur);
        check("fill_block", bus.fill_block, line);
        fills_seen++;
      end
    end
  end

  // Requesters drop req on the cycle their ack is seen.
  task automatic step();
    @(negedge clk3);
    if (bus.ack != '0) bus.req = bus.req & ~bus.ack;
    if (bus2.ack != '0) bus2.req = bus2.req & ~bus2.ack;
  endtask

  task automatic set_addr(input int c, input logic [15:0] a);
    bus.req_addr[c*AW +: AW] = a;
  endtask

  task automatic wait_fill(output int n, input string tag);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.fill_valid && n < 60);
    if (!bus.fill_valid) check({tag, "_timeout"}, bus.fill_valid, 1);
  endtask

  initial begin
    int n;
    int m;
    int issued;
    int fv;
    int order [3];

    bus.req       = '0;
    bus.req_addr  = '0;
    bus2.req      = '0;
    bus2.req_addr = '0;
    repeat (3) @(negedge clk3);
    #2 reset = 1'b1;

    // 1: single request, core 2 @ 0x1234
    step();
    set_addr(2, 16'h1234);
    bus.req = 4'b0100;
    wait_fill(n, "t1");
    check("t1_latency", n, 18);
    check("t1_ack", bus.ack, 4'b0100);
    check("t1_core", bus.fill_core, 2);
    check("t1_line", bus.fill_block, 128'h3f3e3d3c3b3a39383736353433323130);
    step();
    check("t1_idle_busy", bus.busy, 0);

    // 2: after reset, all four cores at once
    #2 reset = 1'b0;
    step();
    #2 reset = 1'b1;
    set_addr(0, 16'h0A05);
    set_addr(1, 16'h1B1A);
    set_addr(2, 16'h2C2F);
    set_addr(3, 16'h3D40);
    bus.req = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      wait_fill(n, "t2");
      check("t2_core", bus.fill_core, j);
      check("t2_spacing", n, (j == 0) ? 18 : 19);
    end
    step();

    // 3: fairness -- core 1, then 1011 gives 3, 0, 1
    set_addr(1, 16'h4455);
    bus.req = 4'b0010;
    wait_fill(n, "t3a");
    check("t3_first", bus.fill_core, 1);
    set_addr(0, 16'h6061);
    set_addr(3, 16'h7072);
    bus.req = 4'b1011;
    order = '{3, 0, 1};
    for (int j = 0; j < 3; j++) begin
      wait_fill(n, "t3");
      check("t3_order", bus.fill_core, order[j]);
    end
    step();

    // 4: reset in cycle 8 of a fill, then restart
    set_addr(1, 16'h5678);
    bus.req = 4'b0010;
    repeat (8) step();
    #2 reset = 1'b0;
    #1;
    check("t4_busy", bus.busy, 0);
    check("t4_mem_en", bus.mem_en, 0);
    check("t4_mem_addr", bus.mem_addr, 0);
    check("t4_fill_block", bus.fill_block, 0);
    step();
    step();
    #2 reset = 1'b1;
    wait_fill(n, "t4");
    check("t4_latency", n, 18);
    check("t4_ack", bus.ack, 4'b0010);
    check("t4_line", bus.fill_block, 128'h7f7e7d7c7b7a79787776757473727170);
    step();

    // 6: core 0 drops req in cycle 5 of its fill
    set_addr(0, 16'h9ABC);
    bus.req = 4'b0001;
    repeat (5) step();
    bus.req[0] = 1'b0;
    wait_fill(m, "t6");
    check("t6_latency", 5 + m, 18);
    check("t6_ack", bus.ack, 4'b0001);
    step();
    check("t6_busy", bus.busy, 0);
    check("t6_fill_valid", bus.fill_valid, 0);

    // 5: second instance, 4-byte lines, MEM_LAT=2, addr 0x00A7
    bus2.req_addr[15:0] = 16'h00A7;
    bus2.req = 4'b0001;
    n = 0;
    issued = 0;
    fv = 0;
    while (fv == 0 && n < 30) begin
      step();
      n++;
      if (bus2.mem_en) begin
        check("t5_addr", bus2.mem_addr, 16'h00A4 + 16'(issued));
        check("t5_issue_cycle", n, issued + 1);
        issued++;
      end
      if (bus2.fill_valid) begin
        fv = n;
        check("t5_line", bus2.fill_block, 32'hA7A6A5A4);
        check("t5_core", bus2.fill_core, 0);
        check("t5_ack", bus2.ack, 4'b0001);
      end
    end
    check("t5_issues", issued, 4);
    check("t5_fill_cycle", fv, 7);

    // Randomized traffic on the main instance
    m = fills_seen;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      for (int i = 0; i < N; i++) begin
        int r;
        r = int'($urandom_range(0, 31));
        if (!bus.req[i]) begin
          if (r < 6) begin
            set_addr(i, 16'($urandom));
            bus.req[i] = 1'b1;
          end
        end else if (r == 0) begin
          bus.req[i] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) set_addr(i, 16'($urandom));
      end
    end
    check("rand_fill_count", (fills_seen - m) > 50, 1);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Shares the single byte-wide main-memory block RAM among the per-core L1 miss paths of the multicore cache simulator.
- Round-robin arbitration picks one pending miss. The block then sequences BLOCK_SIZE_BYTE byte reads from memory and assembles the full line.
- Returns the line to the winning core with a one-cycle valid/ack pulse.
- Sits between the per-core cache controllers and the memory BRAM instance; the BRAM itself stays outside this block.

Parameters:
- NUM_CORES, 4, number of requesting cores (power of 2, 2..8).
- BLOCK_SIZE_BYTE, 16, line size in bytes (4, 8 or 16).
- ADDR_W, 16, byte address width of main memory.
- MEM_LAT, 1, BRAM read latency in cycles (1..3).
- CORE_ID_W, log2(NUM_CORES), derived.
- BO_W, log2(BLOCK_SIZE_BYTE), derived block-offset width.

Ports:
- clk3 in 1: single clock, rising edge.
- reset in 1: asynchronous, active-low reset.
- req in NUM_CORES: per-core miss request; level signal, held until ack.
- req_addr in NUM_CORES*ADDR_W: miss byte address; core i occupies [i*ADDR_W +: ADDR_W].
- ack out NUM_CORES: one-hot, one-cycle pulse to the served core.
- fill_valid out 1: one-cycle pulse; fill_block and fill_core are valid in that cycle.
- fill_core out CORE_ID_W: id of the served core.
- fill_block out BLOCK_SIZE_BYTE*8: assembled line; byte k at [8k +: 8].
- busy out 1: high while a fill is in progress.
- mem_en out 1: BRAM enable.
- mem_addr out ADDR_W: BRAM byte address.
- mem_dout in 8: BRAM read data, valid MEM_LAT cycles after the sampling edge of mem_en/mem_addr.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including ack, fill_valid, fill_core, fill_block, busy, mem_en and mem_addr.
  - Internal state also clears: issue/capture counters 0, rr_ptr 0, valid pipe 0.
  - Any fill in progress is abandoned silently, with no ack.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr upward, wrapping modulo NUM_CORES.
  - Latch the core id and base = req_addr[core] with the low BO_W bits zeroed, then go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - Runs BLOCK_SIZE_BYTE cycles, k = 0..B-1.
  - Each cycle: mem_en=1, mem_addr = base | k.
  - After k = B-1, go to DRAIN.
- Capture:
  - A MEM_LAT-deep valid pipe tracks issued reads.
  - When the pipe output is 1, the byte from mem_dout is written to fill_block[8*cap +: 8] and cap increments.
  - Capture runs concurrently with ISSUE and DRAIN.
- DRAIN: mem_en=0. Wait until cap == B, then go to DONE.
- DONE (exactly one cycle):
  - fill_valid=1, ack[core]=1, fill_core=core.
  - rr_ptr = (core+1) mod NUM_CORES, then go to IDLE.
- busy=1 in ISSUE, DRAIN and DONE.
- fill_block and fill_core hold their values until the next fill's first capture. Bytes not yet written keep their old values.
- Latency: req seen in IDLE at the cycle-0 edge; issues in cycles 1..B; fill_valid in cycle B+MEM_LAT+1 (B=16, MEM_LAT=1 gives cycle 18).
- Back-to-back fills are separated by at least one IDLE cycle.
- Handshake:
  - The requester must drop req no later than the cycle after ack.
  - A req still high in the next IDLE is treated as a new miss.
- req_addr changes after grant are ignored; the address is latched.
- If req drops mid-fill, the fill still completes and ack is still pulsed.
- Requests arriving during busy wait for IDLE; none are lost because req is a level signal.
- mem_addr never carries past the block boundary.
- All requests simultaneous: served in strict rotation from rr_ptr.

Decomposition:
- Shared include/package cache_sim_pkg holds:
  - the log2 helper function;
  - ADDR_W default;
  - FSM state encodings (IDLE=0, ISSUE=1, DRAIN=2, DONE=3).
- One sub-module, rr_arbiter: combinational pick from req and rr_ptr, outputting a one-hot grant plus the encoded id.
  - The pointer register stays in the parent.
- The capture pipe and counters live inline in mem_fill_arbiter.

Test Plan:
1. BRAM model returns the low address byte. Single req core 2, addr 0x1234.
   - mem_addr = 0x1230..0x123F in cycles 1..16.
   - fill_valid and ack=4'b0100 in cycle 18.
   - fill_core=2; fill_block byte k = 0x30+k.
2. After reset, req=4'b1111 with distinct addresses.
   - Served in order 0,1,2,3, each fill_valid 19 cycles apart.
   - Each line matches its own address.
3. Fairness: core 1 is served, then req=4'b1011.
   - Next grants are 3, then 0, then 1.
   - Core 2 is never granted while its req is low.
4. reset=0 asserted in cycle 8 of a fill.
   - Outputs go to 0 immediately; no ack or fill_valid.
   - After release with req still high, the fill restarts from byte 0 and completes 18 cycles later.
5. MEM_LAT=2, BLOCK_SIZE_BYTE=4, addr 0x00A7.
   - mem_addr = 0x00A4..0x00A7.
   - fill_valid in cycle 7.
   - fill_block = 0xA7A6A5A4.
6. Core 0 drops req in cycle 5 of its fill.
   - Fill is still delivered with ack[0] in cycle 18.
   - Arbiter then returns to IDLE with busy=0.
